// File: rtl/pb_evt_pkg.sv
// Shared event encodings, pending-bit positions and width helpers for the
// push-button event controller.
package pb_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_type_e;

  localparam int unsigned EVT_W = 2;

  localparam int unsigned PEND_PRESS   = 0;
  localparam int unsigned PEND_RELEASE = 1;
  localparam int unsigned PEND_LONG    = 2;

  // Width needed to index n items (at least 1 bit).
  function automatic int unsigned btn_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold values 0..max (at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max <= 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One button channel: input synchronizer, tick-based debounce, long-press
// timer and the three pending-event bits.
module pb_channel import pb_evt_pkg::*; #(
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_n,
  input  logic       tick,
  input  logic [2:0] grant,
  output logic       btn_state,
  output logic [2:0] pend,
  output logic       ovf
);

  localparam int unsigned SW = cnt_w(STABLE_TICKS);
  localparam int unsigned HW = cnt_w(LONG_TICKS);

  logic          s_meta;
  logic          s;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic [2:0]    pset;

  always_comb begin
    accept             = tick && (s != btn_state) && (stab_cnt == SW'(STABLE_TICKS - 1));
    pset               = '0;
    pset[PEND_PRESS]   = accept && !btn_state;
    pset[PEND_RELEASE] = accept && btn_state;
    // hold_cnt saturates at LONG_TICKS, so this matches only once per press
    pset[PEND_LONG]    = tick && btn_state && (hold_cnt == HW'(LONG_TICKS - 1));
  end

  // A bit granted this cycle may be re-set without counting as a loss.
  assign ovf = |(pset & pend & ~grant);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_meta    <= 1'b0;
      s         <= 1'b0;
      btn_state <= 1'b0;
      stab_cnt  <= '0;
      hold_cnt  <= '0;
      pend      <= '0;
    end else begin
      s_meta <= ~pb_n;
      s      <= s_meta;
      pend   <= (pend & ~grant) | pset;
      if (tick) begin
        if (s == btn_state) begin
          stab_cnt <= '0;
        end else if (accept) begin
          stab_cnt  <= '0;
          btn_state <= ~btn_state;
        end else begin
          stab_cnt <= stab_cnt + SW'(1);
        end
        if (accept && btn_state) begin
          hold_cnt <= '0;
        end else if (btn_state && (hold_cnt != HW'(LONG_TICKS))) begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pb_event_ctrl.sv
// Multi-button event controller: shared sample-tick prescaler, per-channel
// debounce, round-robin event arbiter and a small valid/ready event FIFO.
module pb_event_ctrl import pb_evt_pkg::*; #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BTN-1:0]              pb_n,
  output logic [N_BTN-1:0]              btn_state,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [btn_idx_w(N_BTN)-1:0]   evt_btn,
  output logic [EVT_W-1:0]              evt_type,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int unsigned BW = btn_idx_w(N_BTN);
  localparam int unsigned TW = cnt_w(TICK_DIV - 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = BW + EVT_W;

  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [2:0]       pend  [N_BTN];
  logic [2:0]       grant [N_BTN];
  logic [N_BTN-1:0] ch_ovf;

  logic [BW-1:0]    rr;
  logic             found;
  logic [BW-1:0]    win;
  logic [2:0]       win_pend;
  logic [2:0]       gnt_bit;
  evt_type_e        gnt_type;
  logic             do_grant;

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [PW:0]      level;
  logic             room;
  logic             push_q;
  logic [EW-1:0]    push_data_q;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic             pop;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) tcnt <= '0;
    else      tcnt <= tick ? '0 : tcnt + TW'(1);
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    pb_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pb_n      (pb_n[g]),
      .tick      (tick),
      .grant     (grant[g]),
      .btn_state (btn_state[g]),
      .pend      (pend[g]),
      .ovf       (ch_ovf[g])
    );
  end

  // The grant is registered (push_q) one cycle before the FIFO write, so the
  // room check counts that in-flight entry as already occupying a slot.
  assign level = wr_ptr - rd_ptr;
  assign room  = (level + (PW+1)'(push_q)) < (PW+1)'(FIFO_DEPTH);

  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_pend = '0;
    for (int unsigned c = 0; c < N_BTN; c++) begin
      if (!found && (c >= 32'(rr)) && (pend[c] != 3'b000)) begin
        found    = 1'b1;
        win      = BW'(c);
        win_pend = pend[c];
      end
    end
    for (int unsigned c = 0; c < N_BTN; c++) begin
      if (!found && (c < 32'(rr)) && (pend[c] != 3'b000)) begin
        found    = 1'b1;
        win      = BW'(c);
        win_pend = pend[c];
      end
    end
    if (win_pend[PEND_PRESS]) begin
      gnt_bit  = 3'b001;
      gnt_type = EVT_PRESS;
    end else if (win_pend[PEND_LONG]) begin
      gnt_bit  = 3'b100;
      gnt_type = EVT_LONG;
    end else begin
      gnt_bit  = 3'b010;
      gnt_type = EVT_RELEASE;
    end
    do_grant = found && room;
    for (int unsigned c = 0; c < N_BTN; c++) begin
      grant[c] = (do_grant && (win == BW'(c))) ? gnt_bit : 3'b000;
    end
  end

  assign evt_valid = (wr_ptr != rd_ptr);
  assign pop       = evt_valid && evt_ready;
  assign head      = mem[rd_ptr[PW-1:0]];
  assign evt_btn   = evt_valid ? head[EW-1:EVT_W] : '0;
  assign evt_type  = evt_valid ? head[EVT_W-1:0]  : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      rr          <= '0;
      overflow    <= 1'b0;
    end else begin
      push_q      <= do_grant;
      push_data_q <= {win, gnt_type};
      if (push_q) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)    rd_ptr <= rd_ptr + (PW+1)'(1);
      if (do_grant) rr <= (win == BW'(N_BTN - 1)) ? '0 : win + BW'(1);
      overflow <= (overflow && !clr_ovf) || (|ch_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (push_q) mem[wr_ptr[PW-1:0]] <= push_data_q;
  end

endmodule
